gated_d_latch: RTL and testbench

Level-sensitive gated D latch with complementary outputs. Transparent while the gate `clk` is high; holds the last value while `clk` is low. Used as a storage primitive and as a reliability/characterisation cell. Sized per bit through WIDTH. An asynchronous active-low reset gives it a defined power-up state.

---
 rtl/gated_d_latch.sv | 29 ++
 tb/tb_gated_d_latch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gated_d_latch.sv
// Level-sensitive gated D latch with complementary outputs and asynchronous
// active-low reset. Transparent while clk is high, holds while clk is low.
module gated_d_latch #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] q_r;

    // Storage node: reset dominates the gate; the gate opens the latch to d.
    always_latch begin
        if (!rst_n) begin
            q_r <= RESET_VALUE;
        end else if (clk) begin
            q_r <= d;
        end
    end

    // Both outputs come from the single storage node, so qb is always ~qa.
    assign qa = q_r;
    assign qb = ~q_r;

endmodule

// File: tb/tb_gated_d_latch.sv
// Directed self-checking bench for gated_d_latch: a 1-bit instance with the
// default reset value and an 8-bit instance resetting to 8'hA5.
module tb_gated_d_latch;

    logic       clk;
    logic       rst_n;
    logic       d1;
    logic       qa1;
    logic       qb1;
    logic [7:0] d8;
    logic [7:0] qa8;
    logic [7:0] qb8;

    int total;
    int bad;

    gated_d_latch #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d1),
        .qa    (qa1),
        .qb    (qb1)
    );

    gated_d_latch #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d8),
        .qa    (qa8),
        .qb    (qb8)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        clk   = 1'b1;
        d1    = 1'b1;
        d8    = 8'hFF;
        #5;
        total++; if (qa1 !== 1'b0) begin bad++; $display("FAIL reset_qa got=%b want=0", qa1); end
        total++; if (qb1 !== 1'b1) begin bad++; $display("FAIL reset_qb got=%b want=1", qb1); end
        d1 = 1'b0;
        #5;
        total++; if (qa1 !== 1'b0 || qb1 !== 1'b1) begin bad++; $display("FAIL reset_dtoggle got qa=%b qb=%b want qa=0 qb=1", qa1, qb1); end
        clk = 1'b0;
        d1  = 1'b1;
        #5;
        clk = 1'b1;
        #5;
        total++; if (qa1 !== 1'b0 || qb1 !== 1'b1) begin bad++; $display("FAIL reset_clktoggle got qa=%b qb=%b want qa=0 qb=1", qa1, qb1); end
    endtask

    task automatic test_truth_table();
        logic [1:0] stim [6];
        logic       exp_qa [6];
        stim[0] = 2'b00; stim[1] = 2'b01; stim[2] = 2'b10;
        stim[3] = 2'b11; stim[4] = 2'b00; stim[5] = 2'b01;
        exp_qa[0] = 1'b0; exp_qa[1] = 1'b0; exp_qa[2] = 1'b0;
        exp_qa[3] = 1'b1; exp_qa[4] = 1'b1; exp_qa[5] = 1'b1;
        clk = 1'b0;
        d1  = 1'b0;
        #5;
        rst_n = 1'b1;
        #5;
        for (int i = 0; i < 6; i++) begin
            // Gate moves first, data 2 ns later, so a falling gate never coincides with d.
            clk = stim[i][1];
            #2;
            d1 = stim[i][0];
            #3;
            total++;
            if (qa1 !== exp_qa[i] || qb1 !== ~exp_qa[i]) begin
                bad++;
                $display("FAIL truth_table step=%0d got qa=%b qb=%b want qa=%b qb=%b",
                         i, qa1, qb1, exp_qa[i], ~exp_qa[i]);
            end
            #5;
        end
    endtask

    task automatic test_transparency();
        logic vals [4];
        vals[0] = 1'b0; vals[1] = 1'b1; vals[2] = 1'b0; vals[3] = 1'b1;
        clk = 1'b1;
        #5;
        for (int i = 0; i < 4; i++) begin
            d1 = vals[i];
            #1;
            total++;
            if (qa1 !== vals[i] || qb1 !== ~vals[i]) begin
                bad++;
                $display("FAIL transparency step=%0d got qa=%b qb=%b want qa=%b", i, qa1, qb1, vals[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic vals [3];
        vals[0] = 1'b0; vals[1] = 1'b1; vals[2] = 1'b0;
        clk = 1'b1;
        d1  = 1'b1;
        #5;
        clk = 1'b0;
        #5;
        for (int i = 0; i < 3; i++) begin
            d1 = vals[i];
            #5;
            total++;
            if (qa1 !== 1'b1 || qb1 !== 1'b0) begin
                bad++;
                $display("FAIL hold step=%0d got qa=%b qb=%b want qa=1 qb=0", i, qa1, qb1);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Entry state: qa1 latched at 1 with clk low.
        rst_n = 1'b0;
        #5;
        total++; if (qa1 !== 1'b0 || qb1 !== 1'b1) begin bad++; $display("FAIL reset_mid_assert got qa=%b qb=%b want qa=0 qb=1", qa1, qb1); end
        d1 = 1'b1;
        #2;
        rst_n = 1'b1;
        #5;
        total++; if (qa1 !== 1'b0) begin bad++; $display("FAIL reset_mid_release_closed got=%b want=0", qa1); end
        clk = 1'b1;
        #1;
        total++; if (qa1 !== 1'b1 || qb1 !== 1'b0) begin bad++; $display("FAIL reset_mid_open got qa=%b qb=%b want qa=1 qb=0", qa1, qb1); end
    endtask

    task automatic test_release_open();
        clk   = 1'b1;
        rst_n = 1'b0;
        d1    = 1'b1;
        #5;
        total++; if (qa1 !== 1'b0) begin bad++; $display("FAIL release_open_inreset got=%b want=0", qa1); end
        rst_n = 1'b1;
        #1;
        total++; if (qa1 !== 1'b1) begin bad++; $display("FAIL release_open_follow got=%b want=1", qa1); end
        d1 = 1'b0;
        #1;
        total++; if (qa1 !== 1'b0 || qb1 !== 1'b1) begin bad++; $display("FAIL release_open_track got qa=%b qb=%b want qa=0 qb=1", qa1, qb1); end
    endtask

    task automatic test_multibit();
        clk   = 1'b0;
        rst_n = 1'b0;
        d8    = 8'h00;
        #5;
        total++; if (qa8 !== 8'hA5) begin bad++; $display("FAIL mb_reset_qa got=%h want=a5", qa8); end
        total++; if (qb8 !== 8'h5A) begin bad++; $display("FAIL mb_reset_qb got=%h want=5a", qb8); end
        rst_n = 1'b1;
        #5;
        total++; if (qa8 !== 8'hA5) begin bad++; $display("FAIL mb_release_closed got=%h want=a5", qa8); end
        clk = 1'b1;
        d8  = 8'h3C;
        #1;
        total++; if (qa8 !== 8'h3C || qb8 !== 8'hC3) begin bad++; $display("FAIL mb_transparent got qa=%h qb=%h want qa=3c qb=c3", qa8, qb8); end
        d8 = 8'h81;
        #1;
        total++; if (qa8 !== 8'h81) begin bad++; $display("FAIL mb_bits got=%h want=81", qa8); end
        d8 = 8'h3C;
        #2;
        clk = 1'b0;
        #2;
        d8 = 8'hFF;
        #5;
        total++; if (qa8 !== 8'h3C || qb8 !== 8'hC3) begin bad++; $display("FAIL mb_hold got qa=%h qb=%h want qa=3c qb=c3", qa8, qb8); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        d1    = 1'b0;
        d8    = 8'h00;
        #5;
        test_reset();
        test_truth_table();
        test_transparency();
        test_hold();
        test_reset_mid();
        test_release_open();
        test_multibit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
